// File: rtl/lcd_gdram_refresh.sv
// Reads the 1024x8 frame RAM row by row and streams it to an ST7920 LCD12864 over its
// 3-wire serial link, with graphic-mode init sent once after reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for Start_Sig
// INIT    | sending 0x30, 0x0C, 0x01, 0x36 (first refresh after reset only)
// ROW_Y   | sending vertical address command 0x80|row[4:0]
// ROW_X   | sending horizontal address command 0x80 (top half) / 0x88 (bottom half)
// FETCH   | frame-RAM address driven, waiting out the read latency
// SEND    | sending one data byte, then next column / next row / done
// DONE    | one-cycle completion pulse
module lcd_gdram_refresh #(
    parameter int CLK_DIV = 25,
    parameter int GAP_CYC = 3600,
    parameter int CLR_CYC = 80000
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic       Start_Sig,
    output logic       Done_Sig,
    output logic       Busy_Sig,
    output logic [9:0] Read_Addr_Sig,
    input  logic [7:0] Read_Data,
    output logic       LCD_CS,
    output logic       LCD_SCLK,
    output logic       LCD_SID
);

    localparam int MAXC = (CLR_CYC > GAP_CYC) ? ((CLR_CYC > CLK_DIV) ? CLR_CYC : CLK_DIV)
                                              : ((GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV);
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] HALF_LD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] CLR_LD  = TW'(CLR_CYC - 1);
    localparam logic [TW-1:0] TIM_ONE = TW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ROW_Y = 3'd2;
    localparam logic [2:0] S_ROW_X = 3'd3;
    localparam logic [2:0] S_FETCH = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]    st_q, st_d;
    logic          init_done_q, init_done_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [5:0]    row_q, row_d;
    logic [3:0]    col_q, col_d;
    logic          fetch_q, fetch_d;
    logic [9:0]    addr_q, addr_d;
    logic [5:0]    row_inc;
    logic [1:0]    init_nxt;

    logic          cs_q, sclk_q, sid_q;
    logic [23:0]   sh_q;
    logic [4:0]    bit_q;
    logic          gap_q;
    logic          long_q;
    logic [TW-1:0] tim_q;

    logic          launch;
    logic          ld_rs;
    logic [7:0]    ld_byte;
    logic          ld_long;
    logic [23:0]   ld_frame;
    logic          tx_done;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h30;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h36;
        endcase
    endfunction

    assign row_inc  = row_q + 6'd1;
    assign init_nxt = init_idx_q + 2'd1;
    // Last cycle of the post-frame gap; the next frame may launch on this same edge.
    assign tx_done  = gap_q && (tim_q == '0);
    assign ld_long  = !ld_rs && (ld_byte == 8'h01);
    assign ld_frame = {5'b11111, 1'b0, ld_rs, 1'b0, ld_byte[7:4], 4'b0000, ld_byte[3:0], 4'b0000};

    always_comb begin
        st_d        = st_q;
        init_done_d = init_done_q;
        init_idx_d  = init_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        fetch_d     = fetch_q;
        addr_d      = addr_q;
        launch      = 1'b0;
        ld_rs       = 1'b0;
        ld_byte     = 8'h00;
        case (st_q)
            S_IDLE: begin
                if (Start_Sig) begin
                    launch = 1'b1;
                    if (init_done_q) begin
                        st_d    = S_ROW_Y;
                        ld_byte = {3'b100, row_q[4:0]};
                    end else begin
                        st_d       = S_INIT;
                        init_idx_d = 2'd0;
                        ld_byte    = init_cmd(2'd0);
                    end
                end
            end
            S_INIT: begin
                if (tx_done) begin
                    launch = 1'b1;
                    if (init_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        st_d        = S_ROW_Y;
                        ld_byte     = {3'b100, row_q[4:0]};
                    end else begin
                        init_idx_d = init_nxt;
                        ld_byte    = init_cmd(init_nxt);
                    end
                end
            end
            S_ROW_Y: begin
                if (tx_done) begin
                    launch  = 1'b1;
                    st_d    = S_ROW_X;
                    ld_byte = row_q[5] ? 8'h88 : 8'h80;
                end
            end
            S_ROW_X: begin
                if (tx_done) begin
                    st_d    = S_FETCH;
                    fetch_d = 1'b0;
                    addr_d  = {row_q, col_q};
                end
            end
            S_FETCH: begin
                // Address went out on FETCH entry; the byte is valid by the second cycle.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    launch  = 1'b1;
                    ld_rs   = 1'b1;
                    ld_byte = Read_Data;
                    st_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_done) begin
                    if (col_q == 4'd15) begin
                        if (row_q == 6'd63) begin
                            st_d = S_DONE;
                        end else begin
                            col_d   = 4'd0;
                            row_d   = row_inc;
                            st_d    = S_ROW_Y;
                            launch  = 1'b1;
                            ld_byte = {3'b100, row_inc[4:0]};
                        end
                    end else begin
                        col_d   = col_q + 4'd1;
                        st_d    = S_FETCH;
                        fetch_d = 1'b0;
                        addr_d  = {row_q, col_q + 4'd1};
                    end
                end
            end
            S_DONE: begin
                st_d  = S_IDLE;
                row_d = 6'd0;
                col_d = 4'd0;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            st_q        <= S_IDLE;
            init_done_q <= 1'b0;
            init_idx_q  <= 2'd0;
            row_q       <= 6'd0;
            col_q       <= 4'd0;
            fetch_q     <= 1'b0;
            addr_q      <= 10'd0;
        end else begin
            st_q        <= st_d;
            init_done_q <= init_done_d;
            init_idx_q  <= init_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            fetch_q     <= fetch_d;
            addr_q      <= addr_d;
        end
    end

    // Serializer: 24 bits MSB first, CLK_DIV low + CLK_DIV high per bit, then a CS-low gap.
    always_ff @(posedge CLOCK) begin
        if (!RST_n) begin
            cs_q   <= 1'b0;
            sclk_q <= 1'b0;
            sid_q  <= 1'b0;
            sh_q   <= 24'd0;
            bit_q  <= 5'd0;
            gap_q  <= 1'b0;
            long_q <= 1'b0;
            tim_q  <= '0;
        end else if (launch) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b0;
            sid_q  <= ld_frame[23];
            sh_q   <= ld_frame;
            bit_q  <= 5'd23;
            gap_q  <= 1'b0;
            long_q <= ld_long;
            tim_q  <= HALF_LD;
        end else if (cs_q) begin
            if (tim_q != '0) begin
                tim_q <= tim_q - TIM_ONE;
            end else if (!sclk_q) begin
                sclk_q <= 1'b1;
                tim_q  <= HALF_LD;
            end else if (bit_q == 5'd0) begin
                sclk_q <= 1'b0;
                cs_q   <= 1'b0;
                sid_q  <= 1'b0;
                gap_q  <= 1'b1;
                tim_q  <= long_q ? CLR_LD : GAP_LD;
            end else begin
                sclk_q <= 1'b0;
                sid_q  <= sh_q[22];
                sh_q   <= {sh_q[22:0], 1'b0};
                bit_q  <= bit_q - 5'd1;
                tim_q  <= HALF_LD;
            end
        end else if (gap_q) begin
            if (tim_q != '0) begin
                tim_q <= tim_q - TIM_ONE;
            end else begin
                gap_q <= 1'b0;
            end
        end
    end

    assign Busy_Sig      = (st_q != S_IDLE);
    assign Done_Sig      = (st_q == S_DONE);
    assign Read_Addr_Sig = addr_q;
    assign LCD_CS        = cs_q;
    assign LCD_SCLK      = sclk_q;
    assign LCD_SID       = sid_q;

endmodule
